// File: rtl/hyperbus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hyperbus_pkg
//  Description : Shared types for the HyperBus configuration-port arbiter:
//                arbiter state encoding and the default register-interface
//                request/response structures.
//  Revision    : 1.0 - initial release
// ============================================================================
package hyperbus_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } arb_state_e;

  // Default register request: address, write flag, data, byte strobes, valid
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } cfg_reg_req_t;

  // Default register response: read data, error flag, ready (completion)
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } cfg_reg_rsp_t;

endpackage : hyperbus_pkg
`default_nettype wire

// File: rtl/hyperbus_cfg_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_cfg_rr_pick
//  Description : Combinational round-robin search. Returns the first set bit
//                of 'valid' at or after 'ptr', wrapping modulo N.
//  Ports       : valid [N]     - request vector
//                ptr   [IdxW]  - search start index (must be < N)
//                index [IdxW]  - selected index (0 when none)
//                any           - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] index,
  output logic                 any
);

  localparam int unsigned IdxW = $clog2(N);
  // One extra bit so ptr + offset cannot overflow before the wrap compare.
  localparam logic [IdxW:0] NumW = (IdxW+1)'(N);

  logic [IdxW:0]   cand;
  logic [IdxW-1:0] sel;
  logic            hit;

  always_comb begin
    cand = '0;
    sel  = '0;
    hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      // Explicit wrap so non-power-of-two N works correctly.
      if (cand >= NumW) begin
        cand = cand - NumW;
      end
      if (!hit && valid[cand[IdxW-1:0]]) begin
        hit = 1'b1;
        sel = cand[IdxW-1:0];
      end
    end
  end

  assign index = sel;
  assign any   = hit;

endmodule : hyperbus_cfg_rr_pick
`default_nettype wire

// File: rtl/hyperbus_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_cfg_arbiter
//  Description : Round-robin arbiter sharing the HyperBus configuration
//                register port among NumReq requesters. The grant is held for
//                one whole transaction (including config-port stalls); a
//                bounded stall timeout returns an error to the requester.
//  Ports       : clk_i      - clock
//                rst_i      - synchronous active-high reset
//                req_i[k]   - requester requests
//                rsp_o[k]   - requester responses
//                cfg_req_o  - request to the config register block
//                cfg_rsp_i  - response from the config register block
//                busy_o     - high while a grant is held
//                timeout_o  - one-cycle pulse when a timeout error is issued
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_cfg_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         reg_req_t     = cfg_reg_req_t,
  parameter type         reg_rsp_t     = cfg_reg_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_req_t req_i [NumReq],
  output reg_rsp_t rsp_o [NumReq],
  output reg_req_t cfg_req_o,
  input  reg_rsp_t cfg_rsp_i,
  output logic     busy_o,
  output logic     timeout_o
);

  localparam int unsigned     IdxW      = $clog2(NumReq);
  // Counter is kept at least one bit wide even with the timeout disabled.
  localparam int unsigned     CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntSat    = '1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);
  localparam bit              TimeoutEn = (TimeoutCycles != 0);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumReq-1:0] req_valid;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic [IdxW-1:0]   gnt_next;

  for (genvar k = 0; k < NumReq; k++) begin : g_valid
    assign req_valid[k] = req_i[k].valid;
  end

  hyperbus_cfg_rr_pick #(
    .N (NumReq)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Requester after the current grant, wrapped by compare.
  assign gnt_next = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + IdxW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    cnt_d     = cnt_q;
    cfg_req_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      rsp_o[k] = '0;
    end
    busy_o    = (state_q != IDLE);
    timeout_o = 1'b0;

    case (state_q)
      IDLE: begin
        // Arbitration cycle only; no response is ever given here.
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        cfg_req_o        = req_i[gnt_idx_q];
        rsp_o[gnt_idx_q] = cfg_rsp_i;
        if (cfg_rsp_i.ready) begin
          rr_ptr_d = gnt_next;
          state_d  = IDLE;
        end else if (!req_i[gnt_idx_q].valid) begin
          // Requester abandoned the transfer: release without a response.
          rr_ptr_d = gnt_next;
          state_d  = IDLE;
        end else begin
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if (TimeoutEn && (cnt_q == CntLast)) begin
            state_d = TOUT;
          end
        end
      end

      TOUT: begin
        rsp_o[gnt_idx_q].ready = 1'b1;
        rsp_o[gnt_idx_q].error = 1'b1;
        timeout_o              = 1'b1;
        rr_ptr_d               = gnt_next;
        state_d                = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : hyperbus_cfg_arbiter
`default_nettype wire
